// File: rtl/decode_stage_if.sv
// Fetch / write-back / execute signal bundle for the decode stage.
// master drives instructions, write-back and execute back-pressure; slave is the stage.
interface decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [5:0]        out_opcode;
    logic [5:0]        out_funct;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_dest;
    logic              out_is_load;
    logic              out_regwrite;

    modport master (
        output in_valid, in_instr, wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_funct, out_rs_data, out_rt_data,
               out_imm, out_rt, out_rd, out_dest, out_is_load, out_regwrite
    );

    modport slave (
        input  in_valid, in_instr, wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_funct, out_rs_data, out_rt_data,
               out_imm, out_rt, out_rd, out_dest, out_is_load, out_regwrite
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: register file with write-back bypass, immediate extension,
// load-use hazard detection and a valid/ready ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int REG0_ZERO = 1
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        dest;
        logic              is_load;
        logic              regwrite;
    } idex_t;

    function automatic logic writable(input logic [4:0] a);
        return (32'(a) < 32'(NREGS)) && !((REG0_ZERO != 0) && (a == 5'd0));
    endfunction

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    idex_t             idex_q, idex_d, dec;
    logic              out_valid_q, out_valid_d;

    logic              wr_en;
    logic [5:0]        op;
    logic [4:0]        rs, rt;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              uses_rt, hazard, advance, in_ready;

    assign op    = bus.in_instr[31:26];
    assign rs    = bus.in_instr[25:21];
    assign rt    = bus.in_instr[20:16];
    assign wr_en = bus.wb_en && writable(bus.wb_addr);

    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.wb_addr == 5'(i)) rf_d[i] = bus.wb_data;
            end
        end
    end

    // Out-of-range addresses match no entry and so read 0; a same-cycle
    // write to the read address is forwarded straight from the wb port.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rs == 5'(i)) rs_val = rf_q[i];
            if (rt == 5'(i)) rt_val = rf_q[i];
        end
        if (wr_en && (bus.wb_addr == rs)) rs_val = bus.wb_data;
        if (wr_en && (bus.wb_addr == rt)) rt_val = bus.wb_data;
    end

    always_comb begin
        dec          = '0;
        dec.opcode   = op;
        dec.funct    = bus.in_instr[5:0];
        dec.rs_data  = rs_val;
        dec.rt_data  = rt_val;
        dec.rt       = rt;
        dec.rd       = bus.in_instr[15:11];
        dec.dest     = (op == 6'h00) ? bus.in_instr[15:11] : rt;
        dec.is_load  = (op == 6'h23);
        dec.regwrite = (op == 6'h00) || (op >= 6'h08 && op <= 6'h0F) || (op == 6'h23);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
            dec.imm = {{(DATA_W-16){1'b0}}, bus.in_instr[15:0]};
        else
            dec.imm = {{(DATA_W-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
    end

    always_comb begin
        uses_rt  = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        hazard   = out_valid_q && idex_q.is_load && (idex_q.dest != 5'd0) &&
                   ((idex_q.dest == rs) || (uses_rt && (idex_q.dest == rt)));
        advance  = !out_valid_q || bus.out_ready;
        in_ready = advance && !hazard && !bus.flush;
    end

    // Payload is held across bubbles; only the valid bit is cleared.
    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            if (bus.in_valid && in_ready) begin
                idex_d      = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            idex_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            idex_q      <= idex_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_opcode   = idex_q.opcode;
    assign bus.out_funct    = idex_q.funct;
    assign bus.out_rs_data  = idex_q.rs_data;
    assign bus.out_rt_data  = idex_q.rt_data;
    assign bus.out_imm      = idex_q.imm;
    assign bus.out_rt       = idex_q.rt;
    assign bus.out_rd       = idex_q.rd;
    assign bus.out_dest     = idex_q.dest;
    assign bus.out_is_load  = idex_q.is_load;
    assign bus.out_regwrite = idex_q.regwrite;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed plan items then randomized traffic,
// checked against a register-array reference model of the decode rules.
module tb_decode_stage;
    localparam int DW = 32;
    localparam int NR = 16;

    typedef struct packed {
        logic [5:0]    opcode;
        logic [5:0]    funct;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [4:0]    dest;
        logic          is_load;
        logic          regwrite;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(DW)) bus();
    decode_stage #(.DATA_W(DW), .NREGS(NR), .REG0_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [DW-1:0] ref_rf [32];
    exp_t          sbq[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [DW-1:0] model_read(input logic [4:0] r);
        if (bus.wb_en && bus.wb_addr == r && r != 0 && int'(r) < NR) return bus.wb_data;
        return ref_rf[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        int   opc;
        opc        = int'(ins[31:26]);
        e.opcode   = ins[31:26];
        e.funct    = ins[5:0];
        e.rs_data  = model_read(ins[25:21]);
        e.rt_data  = model_read(ins[20:16]);
        e.rt       = ins[20:16];
        e.rd       = ins[15:11];
        e.dest     = (opc == 0) ? ins[15:11] : ins[20:16];
        e.is_load  = (opc == 35);
        e.regwrite = (opc == 0) || (opc >= 8 && opc <= 15) || (opc == 35);
        if (opc >= 12 && opc <= 14) e.imm = DW'(ins[15:0]);
        else                        e.imm = DW'(signed'(ins[15:0]));
        return e;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    // Monitor + reference model, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        exp_t act, hd;
        logic exp_valid, haz, exp_rdy, urt;
        logic [5:0] opc;
        act = {bus.out_opcode, bus.out_funct, bus.out_rs_data, bus.out_rt_data, bus.out_imm,
               bus.out_rt, bus.out_rd, bus.out_dest, bus.out_is_load, bus.out_regwrite};
        if (!rst_n) begin
            check("reset_outputs", 128'({act, bus.out_valid}), 128'(0));
            check("reset_in_ready", 128'(bus.in_ready), 128'(!bus.flush));
            sbq.delete();
            for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        end else begin
            exp_valid = (sbq.size() != 0);
            hd  = exp_valid ? sbq[0] : '0;
            opc = bus.in_instr[31:26];
            urt = (opc == 6'h00 || opc == 6'h04 || opc == 6'h05 || opc == 6'h2B);
            haz = exp_valid && hd.is_load && hd.dest != 0 &&
                  (hd.dest == bus.in_instr[25:21] || (urt && hd.dest == bus.in_instr[20:16]));
            exp_rdy = !bus.flush && !haz && (!exp_valid || bus.out_ready);
            check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
            check("out_valid", 128'(bus.out_valid), 128'(exp_valid));
            if (exp_valid && bus.out_valid) check("payload", 128'(act), 128'(hd));
            if (exp_valid && (bus.flush || bus.out_ready)) void'(sbq.pop_front());
            if (bus.in_valid && exp_rdy) sbq.push_back(model_decode(bus.in_instr));
            if (bus.wb_en && bus.wb_addr != 0 && int'(bus.wb_addr) < NR)
                ref_rf[bus.wb_addr] = bus.wb_data;
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.wb_en     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [12] = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05,
                                 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02};
        logic [4:0] r1, r2, r3;
        r1 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 19) : $urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 19) : $urandom_range(0, 7));
        r3 = 5'($urandom_range(0, 9));
        return {ops[$urandom_range(0, 11)], r1, r2, r3, 11'($urandom)};
    endfunction

    initial begin
        logic        acc, fl;
        logic [31:0] ins;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00A53820; bus.wb_en = 1'b1;
        bus.wb_addr = 5'd5; bus.wb_data = 32'hFFFF_FFFF; bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        drive(1, 32'h00A53820, 0, 0, 0, 1, 1);           // flush during reset
        drive(1, 32'h00A53820, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        drive(1, 32'h00A53820, 0, 0, 0, 0, 1);           // add r7,r5,r5 after reset
        drive(0, 0, 1, 5'd3, 32'h12345678, 0, 1);
        drive(1, 32'h00600820, 0, 0, 0, 0, 1);           // add r1,r3,r0
        drive(1, 32'h2082FFFF, 1, 5'd4, 32'd7, 0, 1);    // addi r2,r4,-1 with bypass
        drive(1, 32'h3405FFFF, 0, 0, 0, 0, 1);           // ori r5,r0,0xffff
        drive(0, 0, 1, 5'd0, 32'hDEAD, 0, 1);
        drive(1, 32'h00003020, 0, 0, 0, 0, 1);           // add r6,r0,r0
        drive(1, 32'h8C280000, 1, 5'd8, 32'hCAFE, 0, 1); // lw r8,0(r1)
        repeat (2) drive(1, 32'h01084820, 0, 0, 0, 0, 1);// add r9,r8,r8
        drive(1, 32'h8C280000, 0, 0, 0, 0, 1);
        repeat (3) drive(1, 32'h01084820, 0, 0, 0, 0, 0);
        repeat (2) drive(1, 32'h01084820, 0, 0, 0, 0, 1);
        drive(1, 32'h00600820, 0, 0, 0, 0, 0);
        drive(1, 32'h2082FFFF, 0, 0, 0, 1, 0);           // flush while stalled
        drive(1, 32'h2082FFFF, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);

        ins = rand_instr();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            fl  = ($urandom_range(0, 19) == 0);
            if (!bus.in_valid || acc || bus.flush) ins = rand_instr();
            drive($urandom_range(0, 4) != 0, ins, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 19)), $urandom, fl, !fl && ($urandom_range(0, 3) != 0));
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        repeat (4) drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
